seg_scan_driver: RTL and testbench

Multiplexed 8-digit seven-segment display driver that sits directly downstream of the pipeline CPU's 32-bit observation output on the board top. It latches a 32-bit value under an enable and decodes it to hexadecimal. It time-multiplexes the eight digits with a programmable dwell time and inserts a one-cycle anti-ghosting blank at each digit change. It drives the board's active-low segment and digit-select lines.

---
 rtl/seg_pkg.sv | 19 +
 rtl/hex7_decode.sv | 16 +
 rtl/seg_scan_driver.sv | 86 ++++++++
 tb/tb_seg_scan_driver.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] SEL_OFF = 8'hFF;

    // Hex glyphs 0..F; bit 7 (dp) is off in every entry.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic {
        SHOW,
        BLANK
    } scan_state_t;

endpackage

// File: rtl/hex7_decode.sv
// Combinational nibble to active-low 7-segment pattern {g..a}.
// A blanked digit turns all seven segments off.
module hex7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [7:0] glyph;

    assign glyph = SEG_TABLE[nibble];
    assign seg   = blank ? 7'h7F : glyph[6:0];

endmodule

// File: rtl/seg_scan_driver.sv
// 8-digit multiplexed hex display driver with programmable dwell, a one-cycle
// anti-ghosting blank at every digit change, and optional leading-zero blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_en,
    input  logic [31:0] i_data,
    input  logic [7:0]  i_dp,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [31:0]      data_r;
    logic [7:0]       dp_r;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    scan_state_t      state, state_nxt;

    logic [4:0]       nib_base;
    logic [3:0]       nibble;
    logic             lz_blank;
    logic [6:0]       seg7;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        state_nxt = SHOW;
        if (state == SHOW && cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            idx_nxt   = idx + 3'd1;
            state_nxt = BLANK;
        end
    end

    // The output word is built from the digit that will be current after this
    // edge, but from the latch contents as they stand, so a simultaneous load
    // shows up one edge later and never tears a word.
    assign nib_base = {idx_nxt, 2'b00};
    assign nibble   = data_r[nib_base +: 4];
    assign lz_blank = BLANK_LZ && (idx_nxt != 3'd0) && ((data_r >> nib_base) == 32'd0);

    hex7_decode u_decode (
        .nibble (nibble),
        .blank  (lz_blank),
        .seg    (seg7)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= '0;
            dp_r   <= '0;
            cnt    <= '0;
            idx    <= '0;
            state  <= SHOW;
            o_sel  <= SEL_OFF;
            o_seg  <= SEG_OFF;
        end else begin
            if (i_en) begin
                data_r <= i_data;
                dp_r   <= i_dp;
            end
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            state <= state_nxt;
            if (state_nxt == BLANK) begin
                o_sel <= SEL_OFF;
                o_seg <= SEG_OFF;
            end else begin
                o_sel <= ~(8'h01 << idx_nxt);
                o_seg <= {~dp_r[idx_nxt], seg7};
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench: two drivers (leading-zero blanking off and on) are compared
// each cycle against a frame-position reference model of the display.
module tb_seg_scan_driver;

    localparam int SD    = 4;
    localparam int FRAME = 8 * SD;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        i_en   = 1'b0;
    logic [31:0] i_data = '0;
    logic [7:0]  i_dp   = '0;
    logic [7:0]  o_seg, o_sel, lz_seg, lz_sel;

    int checks = 0;
    int errors = 0;

    // Reference model state: edges since reset release and the latched contents.
    int          t      = 0;
    logic [31:0] m_data = '0;
    logic [7:0]  m_dp   = '0;
    logic [15:0] exp_n  = 16'hFFFF;
    logic [15:0] exp_lz = 16'hFFFF;

    logic [7:0] hex_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg_scan_driver #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut (
        .clk(clk), .reset(reset), .i_en(i_en), .i_data(i_data), .i_dp(i_dp),
        .o_seg(o_seg), .o_sel(o_sel)
    );

    seg_scan_driver #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_lz (
        .clk(clk), .reset(reset), .i_en(i_en), .i_data(i_data), .i_dp(i_dp),
        .o_seg(lz_seg), .o_sel(lz_sel)
    );

    always #5 clk = ~clk;

    // Expected {sel, seg} at edge tt after reset release: each slot is SD edges,
    // the last of which is the all-off blank.
    function automatic logic [15:0] model_out(int tt, logic [31:0] d, logic [7:0] dp, bit lz);
        int          p, k;
        logic [31:0] upper;
        logic [7:0]  seg;
        p = (tt - 1) % FRAME;
        k = p / SD;
        if (p % SD == SD - 1) return 16'hFFFF;
        upper = d >> (4 * k);
        seg   = hex_tab[upper[3:0]];
        if (lz && k != 0 && upper == 32'd0) seg = 8'hFF;
        if (dp[k]) seg[7] = 1'b0;
        return {~(8'h01 << k), seg};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            t = 0; m_data = '0; m_dp = '0;
            exp_n = 16'hFFFF; exp_lz = 16'hFFFF;
        end else begin
            t++;
            exp_n  = model_out(t, m_data, m_dp, 1'b0);
            exp_lz = model_out(t, m_data, m_dp, 1'b1);
            if (i_en) begin
                m_data = i_data;
                m_dp   = i_dp;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if ({o_sel, o_seg} !== 16'hFFFF) begin
                errors++;
                $display("FAIL reset_hold got sel=%h seg=%h want sel=ff seg=ff", o_sel, o_seg);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({o_sel, o_seg} !== 16'hFEC0) begin
            errors++;
            $display("FAIL reset_release got sel=%h seg=%h want sel=fe seg=c0", o_sel, o_seg);
        end
        checks++;
        if ({lz_sel, lz_seg} !== 16'hFEC0) begin
            errors++;
            $display("FAIL reset_release_lz got sel=%h seg=%h want sel=fe seg=c0", lz_sel, lz_seg);
        end
    endtask

    // Runs n cycles with the current inputs, comparing both drivers to the model.
    task automatic test_scan(string name, int n, bit rand_data);
        for (int i = 0; i < n; i++) begin
            if (rand_data) i_data = $urandom;
            tick();
            checks++;
            if ({o_sel, o_seg} !== exp_n) begin
                errors++;
                $display("FAIL %s t=%0d got sel=%h seg=%h want %h", name, t, o_sel, o_seg, exp_n);
            end
            checks++;
            if ({lz_sel, lz_seg} !== exp_lz) begin
                errors++;
                $display("FAIL %s_lz t=%0d got sel=%h seg=%h want %h", name, t, lz_sel, lz_seg, exp_lz);
            end
        end
    endtask

    task automatic load(logic [31:0] d, logic [7:0] dp);
        i_data = d; i_dp = dp; i_en = 1'b1;
        test_scan("load", 1, 1'b0);
        i_en = 1'b0;
    endtask

    task automatic test_full_scan();
        load(32'h7654_3210, 8'h00);
        test_scan("full_scan", 2 * FRAME + 4, 1'b0);
    endtask

    task automatic test_latch_hold();
        load(32'h0, 8'h00);
        test_scan("latch_hold", FRAME + 8, 1'b1);
        load(32'hDEAD_BEEF, 8'h00);
        test_scan("latch_pulse", 2 * FRAME, 1'b1);
    endtask

    task automatic test_decimal_point();
        load(32'h0, 8'h01);
        test_scan("decimal_point", FRAME + 2, 1'b0);
    endtask

    task automatic test_blank_lz();
        load(32'h0000_0A05, 8'h00);
        test_scan("lz_a05", FRAME + 2, 1'b0);
        load(32'h0, 8'h00);
        test_scan("lz_zero", FRAME + 2, 1'b0);
        load(32'h0, 8'h80);
        test_scan("lz_dp7", FRAME + 2, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            i_en   = ($urandom_range(0, 9) == 0);
            i_data = $urandom >> $urandom_range(0, 31);
            i_dp   = 8'($urandom);
            test_scan("random", 1, 1'b0);
        end
        i_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        i_en = 1'b1;
        for (int i = 0; i < FRAME + 5; i++) begin
            i_data = $urandom >> $urandom_range(0, 31);
            test_scan("back_to_back", 1, 1'b0);
        end
        i_en = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int  guard = 0;
        load(32'h89AB_CDEF, 8'h5A);
        while (!(((t - 1) % FRAME) / SD == 5 && ((t - 1) % SD) == 1) && guard < 2 * FRAME) begin
            test_scan("pre_reset", 1, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 2 * FRAME) begin
            errors++;
            $display("FAIL reset_mid_scan_reach got t=%0d want digit 5 mid-dwell", t);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({o_sel, o_seg, lz_sel, lz_seg} !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_mid_scan got %h %h %h %h want all ff", o_sel, o_seg, lz_sel, lz_seg);
        end
        reset = 1'b0;
        for (int i = 0; i < SD - 1; i++) begin
            tick();
            checks++;
            if ({o_sel, o_seg} !== 16'hFEC0) begin
                errors++;
                $display("FAIL restart_dwell i=%0d got sel=%h seg=%h want fe c0", i, o_sel, o_seg);
            end
        end
        tick();
        checks++;
        if ({o_sel, o_seg} !== 16'hFFFF) begin
            errors++;
            $display("FAIL restart_blank got sel=%h seg=%h want ff ff", o_sel, o_seg);
        end
        test_scan("post_reset", FRAME, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_latch_hold();
        test_decimal_point();
        test_blank_lz();
        test_random();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
